// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder
//   Registered N-to-2^N one-hot decoder with enable and an auto-scan mode.
//   DECODE drives the line selected by w. SCAN starts at w and rotates the
//   active line, holding each line for dwell+1 cycles. Used for mux/row selects
//   and similar strobes.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   en     in   1        1 = outputs active, 0 = all outputs low
//   mode   in   1        0 = DECODE, 1 = SCAN
//   w      in   SEL_W    select index (DECODE) / scan start index (SCAN)
//   load   in   1        SCAN: restart the scan at w
//   dwell  in   DWELL_W  SCAN: line advances every dwell+1 cycles
//   y      out  NOUT     one-hot select, all zero when idle
//   idx    out  SEL_W    index of the active line
//   wrap   out  1        one-cycle pulse when the scan wraps NOUT-1 -> 0
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | en low: y all zero, dwell counter cleared, idx held
// ST_DECODE| y = 1 << w, follows w every cycle
// ST_SCAN  | y rotates from the start index, dwell+1 cycles per line

module onehot_scan_decoder #(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        w,
   input  logic                    load,
   input  logic [DWELL_W-1:0]      dwell,
   output logic [(2**SEL_W)-1:0]   y,
   output logic [SEL_W-1:0]        idx,
   output logic                    wrap
);

   localparam int NOUT = 2**SEL_W;
   localparam logic [NOUT-1:0]    ONE_Y   = {{(NOUT-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0]   ONE_IDX = {{(SEL_W-1){1'b0}}, 1'b1};
   localparam logic [DWELL_W-1:0] ONE_CNT = {{(DWELL_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NOUT-1:0]      y_q, y_d;
   logic [SEL_W-1:0]     idx_q, idx_d;
   logic                 wrap_q, wrap_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [SEL_W-1:0]     idx_inc;

   // Natural modulo-NOUT wrap of the SEL_W-bit index.
   assign idx_inc = idx_q + ONE_IDX;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         y_q     <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      cnt_d   = cnt_q;

      if (!en) begin
         state_d = ST_IDLE;
         y_d     = '0;
         cnt_d   = '0;
      end else if (!mode) begin
         state_d = ST_DECODE;
         idx_d   = w;
         y_d     = ONE_Y << w;
         cnt_d   = '0;
      end else if ((state_q != ST_SCAN) || load) begin
         // Scan entry and load restart look identical; load wins over an advance.
         state_d = ST_SCAN;
         idx_d   = w;
         y_d     = ONE_Y << w;
         cnt_d   = '0;
      end else if (cnt_q >= dwell) begin
         // >= so a live dwell lowered below the running count advances at once.
         idx_d   = idx_inc;
         y_d     = ONE_Y << idx_inc;
         cnt_d   = '0;
         wrap_d  = (idx_q == {SEL_W{1'b1}});
      end else begin
         // cnt < dwell here, so the increment cannot overflow.
         cnt_d   = cnt_q + ONE_CNT;
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule
